vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Source end of the DrawX/DrawY/blank pixel interface consumed by the sprite/ROM display blocks.
//  Generates 640x480@60Hz VGA raster timing from vga_clk (25 MHz).
//  Outputs the current pixel coordinate, the visible-area flag, and sync pulses.
//  Sync pulses are delayed by PIPE_DELAY so they align with consumers' registered colour path.
//  Also provides frame-start pulse and frame counter for animation logic.
// PARAMETERS
//  H_VISIBLE   640  visible pixels per line
//  H_FRONT     16   horizontal front porch (clocks)
//  H_SYNC      96   horizontal sync width (clocks)
//  H_BACK      48   horizontal back porch (clocks); H_TOTAL = sum = 800
//  V_VISIBLE   480  visible lines per frame
//  V_FRONT     10   vertical front porch (lines)
//  V_SYNC      2    vertical sync width (lines)
//  V_BACK      33   vertical back porch (lines); V_TOTAL = sum = 525
//  PIPE_DELAY  2    clocks of delay on hs/vs (0..7); 2 = ROM read + colour register
// PORTS
//  vga_clk    in   1   pixel clock, all logic on rising edge
//  reset_n    in   1   asynchronous active-low reset
//  DrawX      out  10  current horizontal counter 0..H_TOTAL-1
//  DrawY      out  10  current vertical counter 0..V_TOTAL-1
//  blank      out  1   1 = visible pixel (DrawX<H_VISIBLE && DrawY<V_VISIBLE), 0 = blanking
//  hs         out  1   horizontal sync, active low, delayed PIPE_DELAY clocks
//  vs         out  1   vertical sync, active low, delayed PIPE_DELAY clocks
//  sof        out  1   one-clock pulse, high in cycle DrawX==0 && DrawY==0 after a frame wrap
//  frame_cnt  out  8   completed-frame count, wraps 255->0
// BEHAVIOUR
//  Reset (reset_n low, async, any time incl. mid-frame):
//    hc=vc=0; DrawX=DrawY=0; sof=0; frame_cnt=0; hs=vs=1.
//    Every sync delay-line stage is set to 1, so no spurious sync pulse appears after release.
//  Counters (registered): hc +1 each clock.
//    hc==H_TOTAL-1 -> hc=0, vc +1.
//    hc==H_TOTAL-1 && vc==V_TOTAL-1 -> hc=0, vc=0.
//  DrawX=hc, DrawY=vc directly (no extra latency); blank is a combinational decode of hc/vc.
//  Raw syncs from hc/vc:
//    hs_raw = 0 iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC (656..751).
//    vs_raw = 0 iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (490..491).
//    vs_raw is line-granular and changes at hc==0.
//  Sync delay: hs/vs = raw value PIPE_DELAY clocks earlier, via shift register.
//    PIPE_DELAY=0: hs/vs are raw syncs registered 0 extra cycles (combinational from hc/vc).
//  Frame wrap: on the edge where (hc,vc) goes (799,524)->(0,0):
//    sof<=1 for exactly that one cycle, and frame_cnt<=frame_cnt+1 (mod 256).
//    The first (0,0) after reset is not a wrap: sof stays 0 and frame_cnt is unchanged.
//  Widths: hc, vc are 10 bits; H_TOTAL and V_TOTAL must be <=1024 (elaboration-time assert).
//  No handshake: free-running; consumers sample DrawX/DrawY/blank on the same vga_clk edge.
// TESTING
//  Release reset -> DrawX counts 0,1,2..799 then 0 while DrawY 0->1; blank=1 exactly 640 clocks per line.
//  Line sync: per line, hs low for 96 clocks starting PIPE_DELAY clocks after hc==656; with PIPE_DELAY=2, hs falls at hc==658.
//  Frame: vs low exactly 2 lines (1600 clocks) starting with (hc,vc)=(0+PIPE_DELAY,490); 420000 clocks per frame.
//  Wrap: after (799,524) -> sof=1 one cycle with DrawX=DrawY=0, frame_cnt 0->1; after 256 frames frame_cnt=0.
//  Reset mid-frame at (300,250): outputs clear asynchronously before the next edge; hs/vs=1; no sync/sof glitch after release.
//  PIPE_DELAY=0 build: hs low exactly for hc 656..751, same cycle as DrawX.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA raster timing: pixel coordinates, visible flag, pipeline-aligned
// active-low syncs, frame-start pulse and frame counter.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       sof,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (PIPE_DELAY > 7) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be 0..7");
  end

  logic [9:0] hc;
  logic [9:0] vc;
  logic       hs_raw;
  logic       vs_raw;
  logic       wrap;

  assign wrap = (hc == H_LAST) && (vc == V_LAST);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  // sof is registered from the wrap condition, so the (0,0) seen straight out of reset never pulses
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sof       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      sof <= wrap;
      if (wrap) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign DrawX  = hc;
  assign DrawY  = vc;
  assign blank  = (hc < H_VIS) && (vc < V_VIS);
  assign hs_raw = !((hc >= HS_START) && (hc < HS_END));
  assign vs_raw = !((vc >= VS_START) && (vc < VS_END));

  if (PIPE_DELAY == 0) begin : g_no_pipe
    assign hs = hs_raw;
    assign vs = vs_raw;
  end else begin : g_pipe
    logic [PIPE_DELAY-1:0] hs_pipe;
    logic [PIPE_DELAY-1:0] vs_pipe;

    // Stages reset to the inactive level so release never emits a stale sync pulse
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        hs_pipe <= '1;
        vs_pipe <= '1;
      end else begin
        hs_pipe <= (PIPE_DELAY)'({hs_pipe, hs_raw});
        vs_pipe <= (PIPE_DELAY)'({vs_pipe, vs_raw});
      end
    end

    assign hs = hs_pipe[PIPE_DELAY-1];
    assign vs = vs_pipe[PIPE_DELAY-1];
  end

endmodule
